// File: rtl/automatic_washing_machine.sv
// rtl/automatic_washing_machine.sv - washing machine program sequencer (optional PAUSE_EN: start=0 freezes the program)
// Outputs are decoded from registered state only, so reset clears them asynchronously.
module automatic_washing_machine #(
  parameter int RINSE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic door_close,
  input  logic start,
  input  logic filled,
  input  logic detergent_added,
  input  logic cycle_timeout,
  input  logic drained,
  input  logic spin_timeout,
  output logic door_lock,
  output logic motor_on,
  output logic fill_value_on,
  output logic drain_value_on,
  output logic done,
  output logic soap_wash,
  output logic water_wash
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_ADD_DET, S_CYCLE, S_DRAIN, S_SPIN, S_DONE
  } state_t;

  localparam logic [2:0] RINSE_MAX = 3'(RINSE_CYCLES);

  state_t     state_q, state_d;
  logic       soap_q, soap_d;
  logic       water_q, water_d;
  logic [2:0] rinse_q, rinse_d;
  logic       paused_q, paused_d;
  logic       hold;

`ifdef PAUSE_EN
  assign hold = !start && (state_q inside {S_FILL, S_ADD_DET, S_CYCLE, S_DRAIN, S_SPIN});
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      soap_q   <= 1'b0;
      water_q  <= 1'b0;
      rinse_q  <= 3'd0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      soap_q   <= soap_d;
      water_q  <= water_d;
      rinse_q  <= rinse_d;
      paused_q <= paused_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    soap_d   = soap_q;
    water_d  = water_q;
    rinse_d  = rinse_q;
    paused_d = hold;
    if (!hold) begin
      case (state_q)
        S_IDLE:    if (start && door_close) state_d = S_FILL;
        S_FILL:    if (filled) state_d = water_q ? S_CYCLE : S_ADD_DET;
        S_ADD_DET: if (detergent_added) begin
          state_d = S_CYCLE;
          soap_d  = 1'b1;
        end
        S_CYCLE:   if (cycle_timeout) state_d = S_DRAIN;
        S_DRAIN:   if (drained) begin
          // Leaving any drain ends the soap pass; every later pass is water-only.
          soap_d  = 1'b0;
          water_d = 1'b1;
          if (rinse_q < RINSE_MAX) begin
            state_d = S_FILL;
            rinse_d = rinse_q + 3'd1;
          end else begin
            state_d = S_SPIN;
          end
        end
        S_SPIN:    if (spin_timeout) begin
          state_d = S_DONE;
          soap_d  = 1'b0;
          water_d = 1'b0;
          rinse_d = 3'd0;
        end
        S_DONE:    if (!start) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    door_lock      = 1'b0;
    motor_on       = 1'b0;
    fill_value_on  = 1'b0;
    drain_value_on = 1'b0;
    done           = 1'b0;
    case (state_q)
      S_FILL:    begin door_lock = 1'b1; fill_value_on = 1'b1; end
      S_ADD_DET: door_lock = 1'b1;
      S_CYCLE:   begin door_lock = 1'b1; motor_on = 1'b1; end
      S_DRAIN:   begin door_lock = 1'b1; drain_value_on = 1'b1; end
      S_SPIN:    begin door_lock = 1'b1; motor_on = 1'b1; drain_value_on = 1'b1; end
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
    if (paused_q) begin
      motor_on       = 1'b0;
      fill_value_on  = 1'b0;
      drain_value_on = 1'b0;
    end
  end

  assign soap_wash  = soap_q;
  assign water_wash = water_q;

endmodule

// File: tb/tb_automatic_washing_machine.sv
// tb/tb_automatic_washing_machine.sv - bench for two instances (RINSE_CYCLES=1 and 0) against a program-list model
module tb_automatic_washing_machine;

  localparam int P_IDLE = 0, P_FILL = 1, P_ADD = 2, P_CYC = 3, P_DRN = 4, P_SPIN = 5, P_DONE = 6;

  logic clk = 1'b0;
  logic reset, door_close, start, filled, detergent_added, cycle_timeout, drained, spin_timeout;
  logic [6:0] out0, out1;

  always #5 clk = ~clk;

  automatic_washing_machine #(.RINSE_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset), .door_close(door_close), .start(start), .filled(filled),
    .detergent_added(detergent_added), .cycle_timeout(cycle_timeout), .drained(drained),
    .spin_timeout(spin_timeout), .door_lock(out0[6]), .motor_on(out0[5]),
    .fill_value_on(out0[4]), .drain_value_on(out0[3]), .done(out0[2]),
    .soap_wash(out0[1]), .water_wash(out0[0])
  );

  automatic_washing_machine #(.RINSE_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .door_close(door_close), .start(start), .filled(filled),
    .detergent_added(detergent_added), .cycle_timeout(cycle_timeout), .drained(drained),
    .spin_timeout(spin_timeout), .door_lock(out1[6]), .motor_on(out1[5]),
    .fill_value_on(out1[4]), .drain_value_on(out1[3]), .done(out1[2]),
    .soap_wash(out1[1]), .water_wash(out1[0])
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each instance walks a flat list of program phases; pos 0 is IDLE.
  int prog [2][32];
  int plen [2];
  int pos [2];
  bit paused [2];

  function automatic void build(input int d, input int rinses);
    int n = 0;
    prog[d][n++] = P_IDLE;
    prog[d][n++] = P_FILL; prog[d][n++] = P_ADD; prog[d][n++] = P_CYC; prog[d][n++] = P_DRN;
    for (int r = 0; r < rinses; r++) begin
      prog[d][n++] = P_FILL; prog[d][n++] = P_CYC; prog[d][n++] = P_DRN;
    end
    prog[d][n++] = P_SPIN;
    prog[d][n++] = P_DONE;
    plen[d] = n;
  endfunction

  function automatic logic [6:0] model_out(input int d);
    int ph = prog[d][pos[d]];
    logic lock = 1'b0, mot = 1'b0, fil = 1'b0, drn = 1'b0, dn = 1'b0, soap, water;
    soap  = (pos[d] == 3 || pos[d] == 4);
    water = (pos[d] > 4) && (ph != P_DONE);
    case (ph)
      P_FILL: begin lock = 1; fil = 1; end
      P_ADD:  lock = 1;
      P_CYC:  begin lock = 1; mot = 1; end
      P_DRN:  begin lock = 1; drn = 1; end
      P_SPIN: begin lock = 1; mot = 1; drn = 1; end
      P_DONE: dn = 1;
      default: ;
    endcase
    if (paused[d]) begin mot = 0; fil = 0; drn = 0; end
    return {lock, mot, fil, drn, dn, soap, water};
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int ph = prog[d][pos[d]];
      bit go;
`ifdef PAUSE_EN
      if (!start && ph != P_IDLE && ph != P_DONE) begin
        paused[d] = 1;
        continue;
      end
`endif
      paused[d] = 0;
      case (ph)
        P_IDLE: go = start && door_close;
        P_FILL: go = filled;
        P_ADD:  go = detergent_added;
        P_CYC:  go = cycle_timeout;
        P_DRN:  go = drained;
        P_SPIN: go = spin_timeout;
        default: go = !start;
      endcase
      if (go) pos[d] = (ph == P_DONE) ? 0 : pos[d] + 1;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin pos[d] = 0; paused[d] = 0; end
  endtask

  task automatic run_cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check({tag, "_r1"}, {1'b0, out0}, {1'b0, model_out(0)});
    check({tag, "_r0"}, {1'b0, out1}, {1'b0, model_out(1)});
  endtask

  task automatic clear_sensors();
    filled = 0; detergent_added = 0; cycle_timeout = 0; drained = 0; spin_timeout = 0;
  endtask

  bit saw_done;

  initial begin
    build(0, 1);
    build(1, 0);
    model_reset();
    reset = 1; door_close = 0; start = 0;
    clear_sensors();
    repeat (2) @(negedge clk);
    reset = 0;
    check("reset_r1", {1'b0, out0}, 8'h00);
    check("reset_r0", {1'b0, out1}, 8'h00);

    start = 1;
    repeat (5) run_cycle("interlock");
    door_close = 1;
    run_cycle("door_shut");
    check("door_fill", {6'd0, out0[6], out0[4]}, 8'h03);
    door_close = 0;

    cycle_timeout = 1; drained = 1;
    repeat (10) run_cycle("priority");
    clear_sensors();
    filled = 1;
    run_cycle("to_add");
    filled = 0; detergent_added = 1;
    run_cycle("to_cycle");
    detergent_added = 0;
    run_cycle("in_cycle");
    check("cycle_motor", {7'd0, out0[5]}, 8'h01);

    #2 reset = 1;
    #1;
    check("async_rst_r1", {1'b0, out0}, 8'h00);
    check("async_rst_r0", {1'b0, out1}, 8'h00);
    model_reset();
    @(negedge clk);
    reset = 0;
    start = 0;
    run_cycle("post_reset");

    start = 1; door_close = 1;
    saw_done = 0;
    for (int k = 0; k < 24; k++) begin
      if (k == 2)  filled = 1;
      if (k == 4)  detergent_added = 1;
      if (k == 6)  cycle_timeout = 1;
      if (k == 8)  drained = 1;
      if (k == 10) spin_timeout = 1;
      run_cycle("program");
      if (out0[2]) saw_done = 1;
    end
    check("saw_done", {7'd0, saw_done}, 8'h01);
    start = 0;
    clear_sensors();
    repeat (2) run_cycle("back_idle");

    for (int k = 0; k < 3000; k++) begin
      start           = ($urandom_range(0, 9) != 0);
      door_close      = $urandom_range(0, 1);
      filled          = ($urandom_range(0, 3) == 0);
      detergent_added = ($urandom_range(0, 3) == 0);
      cycle_timeout   = ($urandom_range(0, 3) == 0);
      drained         = ($urandom_range(0, 3) == 0);
      spin_timeout    = ($urandom_range(0, 3) == 0);
      run_cycle("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
